// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: register address map and address width.
package gpio_pkg;

  localparam int GPIO_AW = 3;

  localparam logic [GPIO_AW-1:0] GPIO_OUT     = 3'd0;
  localparam logic [GPIO_AW-1:0] GPIO_IN      = 3'd1;
  localparam logic [GPIO_AW-1:0] GPIO_DIR     = 3'd2;
  localparam logic [GPIO_AW-1:0] GPIO_RISE_EN = 3'd3;
  localparam logic [GPIO_AW-1:0] GPIO_FALL_EN = 3'd4;
  localparam logic [GPIO_AW-1:0] GPIO_PEND    = 3'd5;

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage synchroniser for asynchronous inputs; WIDTH bits, SYNC_STAGES deep.
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  // Shift the asynchronous input through the flop chain; reset clears every stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_irq.sv
// GPIO peripheral: register file, pin synchronisation, edge detection and level irq.
module gpio_irq
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [GPIO_AW-1:0] addr_i,
  input  logic               ren_i,
  output logic [WIDTH-1:0]   rdata_o,
  input  logic               wen_i,
  input  logic [WIDTH-1:0]   wdata_i,
  input  logic [WIDTH-1:0]   phyin_i,
  output logic [WIDTH-1:0]   phyout_o,
  output logic [WIDTH-1:0]   phyoe_o,
  output logic               irq_o
);

  logic [WIDTH-1:0] out_q, dir_q, rise_en_q, fall_en_q, pend_q, prev_q, rdata_q;
  logic [WIDTH-1:0] pend_d, rdata_d;
  logic [WIDTH-1:0] in_s, rise_s, fall_s, clr_s, rd_mux_s;

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (phyin_i),
    .q_o   (in_s)
  );

  assign rise_s = in_s & ~prev_q & rise_en_q;
  assign fall_s = ~in_s & prev_q & fall_en_q;
  assign clr_s  = (wen_i && (addr_i == GPIO_PEND)) ? wdata_i : '0;
  // New edges are ORed in after the clear so a simultaneous set wins.
  assign pend_d = (pend_q & ~clr_s) | rise_s | fall_s;

  // Select read data from the pre-write register values.
  always_comb begin
    rd_mux_s = '0;
    case (addr_i)
      GPIO_OUT:     rd_mux_s = out_q;
      GPIO_IN:      rd_mux_s = in_s;
      GPIO_DIR:     rd_mux_s = dir_q;
      GPIO_RISE_EN: rd_mux_s = rise_en_q;
      GPIO_FALL_EN: rd_mux_s = fall_en_q;
      GPIO_PEND:    rd_mux_s = pend_q;
      default:      rd_mux_s = '0;
    endcase
  end

  // Capture read data on ren, otherwise hold the last value.
  always_comb begin
    rdata_d = rdata_q;
    if (ren_i) begin
      rdata_d = rd_mux_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Register file, edge history, pending bits and read data; reset beats bus traffic.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      prev_q    <= '0;
      rdata_q   <= '0;
    end else begin
      prev_q  <= in_s;
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
      if (wen_i) begin
        case (addr_i)
          GPIO_OUT:     out_q     <= wdata_i;
          GPIO_DIR:     dir_q     <= wdata_i;
          GPIO_RISE_EN: rise_en_q <= wdata_i;
          GPIO_FALL_EN: fall_en_q <= wdata_i;
          default:      ;
        endcase
      end
    end
  end

  assign rdata_o  = rdata_q;
  assign phyout_o = out_q;
  assign phyoe_o  = dir_q;
  assign irq_o    = |pend_q;

endmodule

// File: tb/tb_gpio_irq.sv
// Directed bench for gpio_irq: per-cycle vector table plus hand-written corner sequences.
module tb_gpio_irq;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] addr;
  logic       ren;
  logic       wen;
  logic [7:0] wdata;
  logic [7:0] phyin;
  logic [7:0] rdata;
  logic [7:0] phyout;
  logic [7:0] phyoe;
  logic       irq;

  int n_applied = 0;
  int n_fail    = 0;

  typedef struct {
    logic       ren;
    logic       wen;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] phyin;
    logic [7:0] e_rdata;
    logic [7:0] e_out;
    logic [7:0] e_oe;
    logic       e_irq;
  } vec_t;

  vec_t vecs[$];

  gpio_irq #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .addr_i   (addr),
    .ren_i    (ren),
    .rdata_o  (rdata),
    .wen_i    (wen),
    .wdata_i  (wdata),
    .phyin_i  (phyin),
    .phyout_o (phyout),
    .phyoe_o  (phyoe),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One bus cycle; strobes drop after the edge.
  task automatic step(input logic r, input logic w, input logic [2:0] a, input logic [7:0] d);
    ren = r; wen = w; addr = a; wdata = d;
    cycle();
    ren = 1'b0; wen = 1'b0;
  endtask

  task automatic add(input logic r, input logic w, input logic [2:0] a, input logic [7:0] d,
                     input logic [7:0] pin, input logic [7:0] er, input logic [7:0] eo,
                     input logic [7:0] eoe, input logic ei);
    vec_t v;
    v.ren = r; v.wen = w; v.addr = a; v.wdata = d; v.phyin = pin;
    v.e_rdata = er; v.e_out = eo; v.e_oe = eoe; v.e_irq = ei;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; ren = 1'b0; wen = 1'b0; addr = 3'd0; wdata = 8'h00; phyin = 8'hFF;

    //   ren  wen  addr  wdata  phyin  rdata  out    oe     irq
    add(1'b1,1'b0,3'd1,8'h00,8'hFF,8'h00,8'h00,8'h00,1'b0); // IN read before sync fills
    add(1'b1,1'b0,3'd0,8'h00,8'hFF,8'h00,8'h00,8'h00,1'b0);
    add(1'b1,1'b0,3'd2,8'h00,8'hFF,8'h00,8'h00,8'h00,1'b0);
    add(1'b1,1'b0,3'd3,8'h00,8'hFF,8'h00,8'h00,8'h00,1'b0);
    add(1'b1,1'b0,3'd4,8'h00,8'hFF,8'h00,8'h00,8'h00,1'b0);
    add(1'b1,1'b0,3'd5,8'h00,8'hFF,8'h00,8'h00,8'h00,1'b0);
    add(1'b1,1'b0,3'd6,8'h00,8'hFF,8'h00,8'h00,8'h00,1'b0);
    add(1'b1,1'b0,3'd7,8'h00,8'hFF,8'h00,8'h00,8'h00,1'b0);
    add(1'b0,1'b1,3'd0,8'hA5,8'h80,8'h00,8'hA5,8'h00,1'b0); // OUT=A5
    add(1'b0,1'b1,3'd2,8'h0F,8'h80,8'h00,8'hA5,8'h0F,1'b0); // DIR=0F
    add(1'b1,1'b0,3'd0,8'h00,8'h80,8'hA5,8'hA5,8'h0F,1'b0);
    add(1'b1,1'b0,3'd2,8'h00,8'h80,8'h0F,8'hA5,8'h0F,1'b0);
    add(1'b1,1'b0,3'd1,8'h00,8'h80,8'h80,8'hA5,8'h0F,1'b0); // IN = 80
    add(1'b0,1'b1,3'd3,8'h01,8'h80,8'h80,8'hA5,8'h0F,1'b0); // RISE_EN=01
    add(1'b0,1'b0,3'd0,8'h00,8'h81,8'h80,8'hA5,8'h0F,1'b0); // pin0 rises, edge 1
    add(1'b0,1'b0,3'd0,8'h00,8'h81,8'h80,8'hA5,8'h0F,1'b0); // edge 2
    add(1'b1,1'b0,3'd1,8'h00,8'h81,8'h81,8'hA5,8'h0F,1'b1); // edge 3: IN=81, irq
    add(1'b1,1'b0,3'd5,8'h00,8'h81,8'h01,8'hA5,8'h0F,1'b1);
    add(1'b0,1'b0,3'd0,8'h00,8'h80,8'h01,8'hA5,8'h0F,1'b1); // pin0 falls, not enabled
    add(1'b0,1'b0,3'd0,8'h00,8'h80,8'h01,8'hA5,8'h0F,1'b1);
    add(1'b0,1'b0,3'd0,8'h00,8'h80,8'h01,8'hA5,8'h0F,1'b1);
    add(1'b1,1'b0,3'd5,8'h00,8'h80,8'h01,8'hA5,8'h0F,1'b1);
    add(1'b0,1'b1,3'd4,8'h80,8'h80,8'h01,8'hA5,8'h0F,1'b1); // FALL_EN=80
    add(1'b0,1'b0,3'd0,8'h00,8'h00,8'h01,8'hA5,8'h0F,1'b1); // pin7 falls
    add(1'b0,1'b0,3'd0,8'h00,8'h00,8'h01,8'hA5,8'h0F,1'b1);
    add(1'b0,1'b1,3'd5,8'h01,8'h00,8'h01,8'hA5,8'h0F,1'b1); // W1C 01 as bit7 sets
    add(1'b1,1'b0,3'd5,8'h00,8'h00,8'h80,8'hA5,8'h0F,1'b1);
    add(1'b0,1'b1,3'd5,8'h80,8'h00,8'h80,8'hA5,8'h0F,1'b0); // W1C 80
    add(1'b1,1'b0,3'd5,8'h00,8'h00,8'h00,8'hA5,8'h0F,1'b0);
    add(1'b0,1'b1,3'd1,8'h55,8'h00,8'h00,8'hA5,8'h0F,1'b0); // write IN ignored
    add(1'b0,1'b1,3'd6,8'hFF,8'h00,8'h00,8'hA5,8'h0F,1'b0); // write 6 ignored
    add(1'b1,1'b0,3'd1,8'h00,8'h00,8'h00,8'hA5,8'h0F,1'b0);
    add(1'b1,1'b1,3'd0,8'h3C,8'h00,8'hA5,8'h3C,8'h0F,1'b0); // read+write: pre-write value
    add(1'b1,1'b0,3'd0,8'h00,8'h00,8'h3C,8'h3C,8'h0F,1'b0);

    // Reset with pins high.
    cycle(); cycle(); cycle();
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_phyout", phyout, 8'h00);
    chk("rst_phyoe", phyoe, 8'h00);
    chk("rst_irq", {7'd0, irq}, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      ren = vecs[i].ren; wen = vecs[i].wen; addr = vecs[i].addr;
      wdata = vecs[i].wdata; phyin = vecs[i].phyin;
      cycle();
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
      chk($sformatf("v%0d_phyout", i), phyout, vecs[i].e_out);
      chk($sformatf("v%0d_phyoe", i), phyoe, vecs[i].e_oe);
      chk($sformatf("v%0d_irq", i), {7'd0, irq}, {7'd0, vecs[i].e_irq});
    end
    ren = 1'b0; wen = 1'b0;

    // Set beats clear: W1C of bit0 on the edge its rising edge lands.
    phyin = 8'h01;
    step(1'b0, 1'b0, 3'd0, 8'h00);
    step(1'b0, 1'b0, 3'd0, 8'h00);
    step(1'b1, 1'b1, 3'd5, 8'h01);
    chk("sbc_rdata_pre", rdata, 8'h00);
    chk("sbc_irq", {7'd0, irq}, 8'h01);
    step(1'b1, 1'b1, 3'd5, 8'h01);
    chk("w1c_rdata_preclear", rdata, 8'h01);
    chk("w1c_irq", {7'd0, irq}, 8'h00);

    // Disabling RISE_EN keeps the pending bit.
    phyin = 8'h00;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 8'h00);
    phyin = 8'h01;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 8'h00);
    chk("rise_again_irq", {7'd0, irq}, 8'h01);
    step(1'b0, 1'b1, 3'd3, 8'h00);
    step(1'b1, 1'b0, 3'd5, 8'h00);
    chk("dis_keep_pend", rdata, 8'h01);
    chk("dis_keep_irq", {7'd0, irq}, 8'h01);

    // Fill PEND then reset during an OUT write.
    step(1'b0, 1'b1, 3'd3, 8'hFF);
    phyin = 8'h00;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 8'h00);
    phyin = 8'hFF;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 8'h00);
    step(1'b1, 1'b0, 3'd5, 8'h00);
    chk("pend_full", rdata, 8'hFF);
    rst = 1'b1;
    step(1'b0, 1'b1, 3'd0, 8'h33);
    chk("mid_rst_phyout", phyout, 8'h00);
    chk("mid_rst_irq", {7'd0, irq}, 8'h00);
    chk("mid_rst_rdata", rdata, 8'h00);
    rst = 1'b0;
    step(1'b1, 1'b0, 3'd0, 8'h00);
    chk("post_rst_out", rdata, 8'h00);
    step(1'b1, 1'b0, 3'd5, 8'h00);
    chk("post_rst_pend", rdata, 8'h00);
    chk("post_rst_irq", {7'd0, irq}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule
